program_sequencer: RTL and testbench
====================================

// Module: program_sequencer
// PURPOSE
//  Parametrised instruction sequencer between a program ROM and the cpu core. Fetches {instruction,
//  data} at the program counter, pulses cpu start, waits for the cpu done edge, advances and repeats.
//  Adds run/single-step modes, halt-opcode detection, end-of-ROM stop and a done-timeout watchdog.
// PARAMETERS
//  IW        9      instruction width (opcode in bits [IW-1 -: OPC_W])
//  DW        16     data operand width
//  DEPTH     256    ROM words; AW = $clog2(DEPTH)
//  OPC_W     3      opcode field width
//  HALT_OPC  3'b100 opcode that ends the program (never issued to cpu)
//  TIMEOUT   64     max cycles in WAIT without done edge (>=2)
// PORTS
//  clk        in   1   clock, all logic on posedge
//  rst        in   1   reset, synchronous, active-high
//  run        in   1   level; 1 = execute, 0 = stop at next instruction boundary
//  step_mode  in   1   1 = pause after each retired instruction
//  step_req   in   1   one-cycle pulse; releases one instruction in PAUSE
//  rom_addr   out  AW  ROM address (registered)
//  rom_instr  in   IW  ROM instruction, valid 1 cycle after rom_addr
//  rom_data   in   DW  ROM data operand, valid 1 cycle after rom_addr
//  cpu_start  out  1   one-cycle issue pulse
//  cpu_instr  out  IW  held instruction to cpu
//  cpu_data   out  DW  held data to cpu
//  cpu_done   in   1   cpu completion level; rising edge = retire
//  pc         out  AW  current program counter
//  retired    out  16  retired-instruction count, saturates at 16'hFFFF
//  halted     out  1   sticky: halt opcode, end of ROM or timeout
//  timeout    out  1   sticky: halt caused by watchdog
// BEHAVIOUR
//  Reset: state IDLE; pc, rom_addr, retired, wdog = 0; cpu_instr, cpu_data = 0; cpu_start, halted,
//   timeout = 0; done_q = 0. Reset mid-operation aborts immediately, no further cpu_start.
//  done_rise = cpu_done & ~done_q (done_q registered each cycle); ignored outside WAIT.
//  FSM:
//   IDLE  : run=1 & ~halted -> FETCH.
//   FETCH : rom_addr <= pc; -> LATCH (1 cycle ROM latency).
//   LATCH : cpu_instr/cpu_data <= rom_instr/rom_data; opcode==HALT_OPC -> HALT (no start, no retire);
//           else -> ISSUE.
//   ISSUE : cpu_start=1 this cycle only; wdog<=0; -> WAIT.
//   WAIT  : done_rise -> retired++ (sat); if pc==DEPTH-1 -> HALT (no wrap); else pc++ and
//           step_mode ? PAUSE : (run ? FETCH : IDLE).
//           no done_rise: wdog++; wdog==TIMEOUT-1 -> HALT, timeout<=1. done_rise same cycle wins.
//   PAUSE : step_req -> FETCH; run=0 -> IDLE; step_mode cleared -> FETCH.
//   HALT  : halted=1; stays until rst. run/step_req ignored.
//  Latency: FETCH->ISSUE = 2 cycles; done_rise to next cpu_start = 3 cycles in run mode.
//  cpu_instr/cpu_data stable from LATCH until next LATCH. pc holds in IDLE (run drop = pause).
//  run dropped during WAIT: current instruction completes and retires, then IDLE.
// TESTING
//  1 Prog LOAD r0,5 / LOAD r1,4 / ADD / HALT, run=1, cpu model done 4 cyc after start ->
//    3 start pulses, retired=3, pc=3, halted=1, timeout=0, no 4th start.
//  2 Same prog, step_mode=1: 1 start then PAUSE; each step_req -> exactly one more start; HALT after 3.
//  3 Cpu model never raises done: halted=1 & timeout=1 exactly TIMEOUT cycles after ISSUE; retired=0.
//  4 DEPTH=4, no halt opcode: 4 retires, pc stays 3, halted=1, rom_addr never 0 again.
//  5 rst asserted in WAIT: next cycle state IDLE, pc=0, retired=0, cpu_start=0; run again restarts at 0.
//  6 run dropped in WAIT -> instruction retires, IDLE, pc+1 held; run=1 resumes at that pc.

Source files
------------

// File: rtl/program_sequencer.sv
// Instruction sequencer between a program ROM and the cpu core: fetch, issue, wait for retire,
// advance. Run/single-step modes, halt opcode, end-of-ROM stop and a done-timeout watchdog.
module program_sequencer #(
    parameter int unsigned IW = 9,
    parameter int unsigned DW = 16,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned OPC_W = 3,
    parameter logic [OPC_W-1:0] HALT_OPC = 3'b100,
    parameter int unsigned TIMEOUT = 64,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          step_mode,
    input  logic          step_req,
    output logic [AW-1:0] rom_addr,
    input  logic [IW-1:0] rom_instr,
    input  logic [DW-1:0] rom_data,
    output logic          cpu_start,
    output logic [IW-1:0] cpu_instr,
    output logic [DW-1:0] cpu_data,
    input  logic          cpu_done,
    output logic [AW-1:0] pc,
    output logic [15:0]   retired,
    output logic          halted,
    output logic          timeout
);

    localparam int unsigned WW = $clog2(TIMEOUT);
    localparam logic [AW-1:0] LastPc = AW'(DEPTH - 1);
    localparam logic [WW-1:0] WdogLast = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StIssue,
        StWait,
        StPause,
        StHalt
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic [15:0]   retired_q, retired_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic [IW-1:0] cpu_instr_q, cpu_instr_d;
    logic [DW-1:0] cpu_data_q, cpu_data_d;
    logic          halted_q, halted_d;
    logic          timeout_q, timeout_d;
    logic          done_q;
    logic          done_rise;
    logic [WW-1:0] wdog_inc;

    assign done_rise = cpu_done & ~done_q;
    assign wdog_inc  = wdog_q + WW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            rom_addr_q  <= '0;
            retired_q   <= '0;
            wdog_q      <= '0;
            cpu_instr_q <= '0;
            cpu_data_q  <= '0;
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            rom_addr_q  <= rom_addr_d;
            retired_q   <= retired_d;
            wdog_q      <= wdog_d;
            cpu_instr_q <= cpu_instr_d;
            cpu_data_q  <= cpu_data_d;
            halted_q    <= halted_d;
            timeout_q   <= timeout_d;
            done_q      <= cpu_done;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        rom_addr_d  = rom_addr_q;
        retired_d   = retired_q;
        wdog_d      = wdog_q;
        cpu_instr_d = cpu_instr_q;
        cpu_data_d  = cpu_data_q;
        halted_d    = halted_q;
        timeout_d   = timeout_q;
        cpu_start   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (run && !halted_q) state_d = StFetch;
            end
            StFetch: begin
                rom_addr_d = pc_q;
                state_d    = StLatch;
            end
            StLatch: begin
                cpu_instr_d = rom_instr;
                cpu_data_d  = rom_data;
                if (rom_instr[IW-1 -: OPC_W] == HALT_OPC) begin
                    state_d  = StHalt;
                    halted_d = 1'b1;
                end else begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cpu_start = 1'b1;
                wdog_d    = '0;
                state_d   = StWait;
            end
            StWait: begin
                // A retire in the same cycle as watchdog expiry takes priority.
                if (done_rise) begin
                    if (retired_q != 16'hFFFF) retired_d = retired_q + 16'd1;
                    if (pc_q == LastPc) begin
                        state_d  = StHalt;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc_q + AW'(1);
                        if (step_mode)  state_d = StPause;
                        else if (run)   state_d = StFetch;
                        else            state_d = StIdle;
                    end
                end else begin
                    wdog_d = wdog_inc;
                    if (wdog_inc == WdogLast) begin
                        state_d   = StHalt;
                        halted_d  = 1'b1;
                        timeout_d = 1'b1;
                    end
                end
            end
            StPause: begin
                if (step_req)        state_d = StFetch;
                else if (!run)       state_d = StIdle;
                else if (!step_mode) state_d = StFetch;
            end
            StHalt: begin
                halted_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    assign rom_addr  = rom_addr_q;
    assign cpu_instr = cpu_instr_q;
    assign cpu_data  = cpu_data_q;
    assign pc        = pc_q;
    assign retired   = retired_q;
    assign halted    = halted_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: ROM array, latency-programmable cpu model and a reference
// model that walks the program by the sequencing rules to predict issues, retires and final pc.
module tb_program_sequencer;

    localparam int unsigned IW = 9;
    localparam int unsigned DW = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW = 2;
    localparam int unsigned OPC_W = 3;
    localparam logic [2:0] HALT_OPC = 3'b100;
    localparam int unsigned TIMEOUT = 16;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic          step_mode;
    logic          step_req;
    logic [AW-1:0] rom_addr;
    logic [IW-1:0] rom_instr;
    logic [DW-1:0] rom_data;
    logic          cpu_start;
    logic [IW-1:0] cpu_instr;
    logic [DW-1:0] cpu_data;
    logic          cpu_done = 1'b0;
    logic [AW-1:0] pc;
    logic [15:0]   retired;
    logic          halted;
    logic          timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    program_sequencer #(
        .IW(IW), .DW(DW), .DEPTH(DEPTH), .OPC_W(OPC_W), .HALT_OPC(HALT_OPC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .step_mode(step_mode), .step_req(step_req),
        .rom_addr(rom_addr), .rom_instr(rom_instr), .rom_data(rom_data),
        .cpu_start(cpu_start), .cpu_instr(cpu_instr), .cpu_data(cpu_data), .cpu_done(cpu_done),
        .pc(pc), .retired(retired), .halted(halted), .timeout(timeout)
    );

    logic [IW-1:0] rom_i [DEPTH];
    logic [DW-1:0] rom_d [DEPTH];
    assign rom_instr = rom_i[rom_addr];
    assign rom_data  = rom_d[rom_addr];

    // cpu model: done rises lat cycles after a start pulse (lat = 0 means never) and holds
    int cyc = 0;
    int cnt = 0;
    int lat = 4;
    int start_cyc = 0;
    int halt_cyc = 0;
    int addr0_cnt = 0;
    logic halted_prev = 1'b0;
    logic [IW+DW-1:0] issued [$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            cpu_done = 1'b0;
            cnt = 0;
        end else if (cpu_start) begin
            issued.push_back({cpu_instr, cpu_data});
            start_cyc = cyc;
            cpu_done = 1'b0;
            cnt = lat;
        end else if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) cpu_done = 1'b1;
        end
        if (halted && !halted_prev) halt_cyc = cyc;
        halted_prev = halted;
        if (rom_addr == '0) addr0_cnt = addr0_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        step_mode = 1'b0;
        step_req = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (issued.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_retired(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (int'(retired) >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_halted(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (halted) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic load_fixed(input logic [DW-1:0] a, input logic [DW-1:0] b);
        rom_i[0] = {OP_LOAD, 6'd0}; rom_d[0] = a;
        rom_i[1] = {OP_LOAD, 6'd1}; rom_d[1] = b;
        rom_i[2] = {OP_ADD, 6'd2};  rom_d[2] = '0;
        rom_i[3] = {HALT_OPC, 6'd0}; rom_d[3] = '0;
    endtask

    task automatic load_random(input bit allow_halt);
        logic [2:0] opc;
        for (int i = 0; i < int'(DEPTH); i++) begin
            opc = 3'($urandom_range(0, 7));
            if (opc == HALT_OPC) opc = OP_ADD;
            if (allow_halt && $urandom_range(0, 3) == 0) opc = HALT_OPC;
            rom_i[i] = {opc, 6'($urandom)};
            rom_d[i] = 16'($urandom);
        end
    endtask

    // Walk the program from `start`: halt opcode stops before issue, last word stops after retire.
    function automatic void ref_run(input int start, output int n_exec, output int final_pc);
        logic [IW-1:0] w;
        int a;
        a = start;
        n_exec = 0;
        final_pc = start;
        for (int k = 0; k < int'(DEPTH); k++) begin
            w = rom_i[a];
            if (w[IW-1 -: OPC_W] == HALT_OPC) begin
                final_pc = a;
                return;
            end
            n_exec = n_exec + 1;
            if (a == int'(DEPTH) - 1) begin
                final_pc = a;
                return;
            end
            a = a + 1;
        end
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (pc !== '0) begin errors++; $display("FAIL reset_pc got %0d exp 0", pc); end
        checks++; if (rom_addr !== '0) begin errors++; $display("FAIL reset_rom_addr got %0d exp 0", rom_addr); end
        checks++; if (retired !== 16'd0) begin errors++; $display("FAIL reset_retired got %0d exp 0", retired); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout); end
        checks++; if (cpu_start !== 1'b0) begin errors++; $display("FAIL reset_cpu_start got %b exp 0", cpu_start); end
        checks++; if ({cpu_instr, cpu_data} !== '0) begin errors++; $display("FAIL reset_cpu_bus got %h exp 0", {cpu_instr, cpu_data}); end
        repeat (8) tick();
        checks++; if (issued.size() != 0) begin errors++; $display("FAIL idle_no_start got %0d exp 0", issued.size()); end
    endtask

    task automatic test_run();
        int base;
        bit ok;
        load_fixed(16'd5, 16'd4);
        lat = 4;
        do_reset();
        base = issued.size();
        run = 1'b1;
        wait_halted(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL run_halt_wait got timeout exp halted"); end
        repeat (20) tick();
        checks++; if (issued.size() - base != 3) begin errors++; $display("FAIL run_starts got %0d exp 3", issued.size() - base); end
        checks++; if (retired !== 16'd3) begin errors++; $display("FAIL run_retired got %0d exp 3", retired); end
        checks++; if (pc !== AW'(3)) begin errors++; $display("FAIL run_pc got %0d exp 3", pc); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL run_timeout got %b exp 0", timeout); end
        for (int i = 0; i < 3 && base + i < issued.size(); i++) begin
            checks++;
            if (issued[base+i] !== {rom_i[i], rom_d[i]}) begin
                errors++; $display("FAIL run_word%0d got %h exp %h", i, issued[base+i], {rom_i[i], rom_d[i]});
            end
        end
    endtask

    task automatic test_random_programs();
        int base, n_exp, pc_exp;
        bit ok;
        for (int it = 0; it < 6; it++) begin
            load_random(1'b1);
            lat = $urandom_range(1, 6);
            do_reset();
            base = issued.size();
            run = 1'b1;
            ref_run(0, n_exp, pc_exp);
            wait_halted(300, ok);
            repeat (10) tick();
            checks++; if (!ok) begin errors++; $display("FAIL rand%0d_halt_wait got timeout exp halted", it); end
            checks++; if (issued.size() - base != n_exp) begin errors++; $display("FAIL rand%0d_starts got %0d exp %0d", it, issued.size() - base, n_exp); end
            checks++; if (int'(retired) != n_exp) begin errors++; $display("FAIL rand%0d_retired got %0d exp %0d", it, retired, n_exp); end
            checks++; if (int'(pc) != pc_exp) begin errors++; $display("FAIL rand%0d_pc got %0d exp %0d", it, pc, pc_exp); end
            checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rand%0d_timeout got %b exp 0", it, timeout); end
            for (int i = 0; i < n_exp && base + i < issued.size(); i++) begin
                checks++;
                if (issued[base+i] !== {rom_i[i], rom_d[i]}) begin
                    errors++; $display("FAIL rand%0d_word%0d got %h exp %h", it, i, issued[base+i], {rom_i[i], rom_d[i]});
                end
            end
        end
    endtask

    task automatic test_step();
        int base;
        bit ok;
        load_fixed(16'($urandom), 16'($urandom));
        lat = $urandom_range(1, 5);
        do_reset();
        base = issued.size();
        step_mode = 1'b1;
        run = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) begin
                step_req = 1'b1;
                tick();
                step_req = 1'b0;
            end
            wait_retired(k, 100, ok);
            checks++; if (!ok) begin errors++; $display("FAIL step%0d_retire_wait got %0d exp %0d", k, retired, k); end
            repeat (10) tick();
            checks++; if (issued.size() - base != k) begin errors++; $display("FAIL step%0d_starts got %0d exp %0d", k, issued.size() - base, k); end
        end
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        wait_halted(50, ok);
        repeat (5) tick();
        checks++; if (!ok) begin errors++; $display("FAIL step_halt_wait got timeout exp halted"); end
        checks++; if (issued.size() - base != 3) begin errors++; $display("FAIL step_total_starts got %0d exp 3", issued.size() - base); end
        checks++; if (retired !== 16'd3) begin errors++; $display("FAIL step_retired got %0d exp 3", retired); end
        step_mode = 1'b0;
    endtask

    task automatic test_timeout();
        int base;
        bit ok;
        load_random(1'b0);
        lat = 0;
        do_reset();
        base = issued.size();
        run = 1'b1;
        wait_halted(200, ok);
        tick();
        checks++; if (!ok) begin errors++; $display("FAIL wdog_halt_wait got timeout exp halted"); end
        checks++; if (halt_cyc - start_cyc != int'(TIMEOUT)) begin errors++; $display("FAIL wdog_delay got %0d exp %0d", halt_cyc - start_cyc, TIMEOUT); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL wdog_flag got %b exp 1", timeout); end
        checks++; if (retired !== 16'd0) begin errors++; $display("FAIL wdog_retired got %0d exp 0", retired); end
        checks++; if (issued.size() - base != 1) begin errors++; $display("FAIL wdog_starts got %0d exp 1", issued.size() - base); end
    endtask

    task automatic test_end_of_rom();
        int base, a0;
        bit ok;
        load_random(1'b0);
        lat = $urandom_range(1, 6);
        do_reset();
        base = issued.size();
        run = 1'b1;
        wait_starts(base + 2, 100, ok);
        a0 = addr0_cnt;
        wait_halted(300, ok);
        repeat (20) tick();
        checks++; if (!ok) begin errors++; $display("FAIL eor_halt_wait got timeout exp halted"); end
        checks++; if (addr0_cnt != a0) begin errors++; $display("FAIL eor_no_wrap got %0d exp %0d", addr0_cnt, a0); end
        checks++; if (retired !== 16'd4) begin errors++; $display("FAIL eor_retired got %0d exp 4", retired); end
        checks++; if (pc !== AW'(3)) begin errors++; $display("FAIL eor_pc got %0d exp 3", pc); end
        checks++; if (rom_addr !== AW'(3)) begin errors++; $display("FAIL eor_rom_addr got %0d exp 3", rom_addr); end
        checks++; if (issued.size() - base != 4) begin errors++; $display("FAIL eor_starts got %0d exp 4", issued.size() - base); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL eor_timeout got %b exp 0", timeout); end
    endtask

    task automatic test_reset_mid();
        int base, n0;
        bit ok;
        load_random(1'b0);
        lat = 6;
        do_reset();
        base = issued.size();
        run = 1'b1;
        wait_starts(base + 2, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_start_wait got %0d exp 2", issued.size() - base); end
        rst = 1'b1;
        tick();
        checks++; if (pc !== '0) begin errors++; $display("FAIL rstmid_pc got %0d exp 0", pc); end
        checks++; if (retired !== 16'd0) begin errors++; $display("FAIL rstmid_retired got %0d exp 0", retired); end
        checks++; if (cpu_start !== 1'b0) begin errors++; $display("FAIL rstmid_cpu_start got %b exp 0", cpu_start); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rstmid_halted got %b exp 0", halted); end
        n0 = issued.size();
        run = 1'b0;
        repeat (6) tick();
        checks++; if (issued.size() != n0) begin errors++; $display("FAIL rstmid_no_start got %0d exp %0d", issued.size(), n0); end
        rst = 1'b0;
        run = 1'b1;
        wait_starts(n0 + 1, 100, ok);
        checks++; if (!ok || issued[n0] !== {rom_i[0], rom_d[0]}) begin errors++; $display("FAIL rstmid_restart_word got %0d exp 1 start of word 0", issued.size() - n0); end
        wait_halted(300, ok);
        checks++; if (!ok || retired !== 16'd4) begin errors++; $display("FAIL rstmid_final_retired got %0d exp 4", retired); end
    endtask

    task automatic test_run_drop();
        int base;
        bit ok;
        load_random(1'b0);
        lat = 5;
        do_reset();
        base = issued.size();
        run = 1'b1;
        wait_starts(base + 1, 100, ok);
        run = 1'b0;
        wait_retired(1, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL drop_retire_wait got %0d exp 1", retired); end
        repeat (10) tick();
        checks++; if (pc !== AW'(1)) begin errors++; $display("FAIL drop_pc got %0d exp 1", pc); end
        checks++; if (issued.size() - base != 1) begin errors++; $display("FAIL drop_starts got %0d exp 1", issued.size() - base); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL drop_halted got %b exp 0", halted); end
        run = 1'b1;
        wait_starts(base + 2, 100, ok);
        checks++; if (!ok || issued[base+1] !== {rom_i[1], rom_d[1]}) begin errors++; $display("FAIL drop_resume_word got %0d starts exp 2 with word 1", issued.size() - base); end
        wait_halted(300, ok);
        checks++; if (!ok || retired !== 16'd4) begin errors++; $display("FAIL drop_final_retired got %0d exp 4", retired); end
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        step_mode = 1'b0;
        step_req = 1'b0;
        test_reset();
        test_run();
        test_random_programs();
        test_step();
        test_timeout();
        test_end_of_rom();
        test_reset_mid();
        test_run_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_time_limit got expired exp finish");
        $fatal(1);
    end

endmodule
